rat_input_port: RTL and testbench

//  Input-side peripheral for the RAT MCU: the read path of the PORT_ID/IO_STRB

---
 rtl/rat_input_port.sv | 187 ++++++++++++++++++
 tb/tb_rat_input_port.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rat_input_port.sv
// rat_input_port: input-side peripheral for the RAT MCU.
// Synchronises switches and push-buttons, debounces each button, latches
// button-press events as pending interrupt sources, and serves IN reads
// and OUT writes on the PORT_ID/IO_STRB bus.
module rat_input_port #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter logic [7:0]  SWITCHES_ID     = 8'hFF,
    parameter logic [7:0]  BTN_LEVEL_ID    = 8'hFD,
    parameter logic [7:0]  EVENT_ID        = 8'hFE,
    parameter logic [7:0]  INTR_ACK_ID     = 8'h82,
    parameter logic [7:0]  INTR_MASK_ID    = 8'h83
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [7:0] i_switches,
    input  logic [3:0] i_buttons,
    input  logic [7:0] i_port_id,
    input  logic [7:0] i_out_port,
    input  logic       i_io_strb,
    output logic [7:0] o_in_port,
    output logic       o_intr
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // The sample that moves IDLE into WAIT already counts as the first stable
    // cycle, so the level is accepted once DEBOUNCE_CYCLES samples agree.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } db_state_t;

    logic [7:0] r_sw_meta;
    logic [7:0] r_sw_s;
    logic [3:0] r_btn_meta;
    logic [3:0] r_btn_s;

    logic [3:0] w_level;
    logic [3:0] w_set;
    logic [3:0] w_clear;
    logic [3:0] w_pending_next;
    logic [3:0] w_mask_next;
    logic [3:0] r_pending;
    logic [3:0] r_mask;
    logic       r_intr;

    // Two-flop synchronisers for the asynchronous board inputs
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_sw_meta  <= 8'h00;
            r_sw_s     <= 8'h00;
            r_btn_meta <= 4'h0;
            r_btn_s    <= 4'h0;
        end else begin
            r_sw_meta  <= i_switches;
            r_sw_s     <= r_sw_meta;
            r_btn_meta <= i_buttons;
            r_btn_s    <= r_btn_meta;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_debounce
            db_state_t        r_state;
            db_state_t        w_state_next;
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] w_cnt_next;
            logic             w_lvl;
            logic             w_rise;

            // Debounce state and stable-cycle counter
            always_ff @(posedge i_clk) begin
                if (!i_reset_n) begin
                    r_state <= IDLE_LO;
                    r_cnt   <= '0;
                end else begin
                    r_state <= w_state_next;
                    r_cnt   <= w_cnt_next;
                end
            end

            // Next state: a level must hold for DEBOUNCE_CYCLES samples; any
            // reversion during the wait drops back to the old idle state
            always_comb begin
                w_state_next = r_state;
                w_cnt_next   = r_cnt;
                case (r_state)
                    IDLE_LO: begin
                        if (r_btn_s[gi]) begin
                            if (DEBOUNCE_CYCLES == 1) begin
                                w_state_next = IDLE_HI;
                                w_cnt_next   = '0;
                            end else begin
                                w_state_next = WAIT_HI;
                                w_cnt_next   = CNT_W'(1);
                            end
                        end
                    end
                    WAIT_HI: begin
                        if (!r_btn_s[gi]) begin
                            w_state_next = IDLE_LO;
                            w_cnt_next   = '0;
                        end else if (r_cnt == CNT_LAST) begin
                            w_state_next = IDLE_HI;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = r_cnt + CNT_W'(1);
                        end
                    end
                    IDLE_HI: begin
                        if (!r_btn_s[gi]) begin
                            if (DEBOUNCE_CYCLES == 1) begin
                                w_state_next = IDLE_LO;
                                w_cnt_next   = '0;
                            end else begin
                                w_state_next = WAIT_LO;
                                w_cnt_next   = CNT_W'(1);
                            end
                        end
                    end
                    WAIT_LO: begin
                        if (r_btn_s[gi]) begin
                            w_state_next = IDLE_HI;
                            w_cnt_next   = '0;
                        end else if (r_cnt == CNT_LAST) begin
                            w_state_next = IDLE_LO;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        w_state_next = IDLE_LO;
                        w_cnt_next   = '0;
                    end
                endcase
            end

            // Outputs: debounced level from the state, press event on entry to IDLE_HI from the low side
            always_comb begin
                w_lvl  = (r_state == IDLE_HI) || (r_state == WAIT_LO);
                w_rise = ((r_state == IDLE_LO) || (r_state == WAIT_HI)) &&
                         (w_state_next == IDLE_HI);
            end

            assign w_level[gi] = w_lvl;
            assign w_set[gi]   = w_rise;
        end
    endgenerate

    // OUT decode: acknowledge clears, mask load; a new event beats a same-cycle clear
    always_comb begin
        w_clear        = (i_io_strb && (i_port_id == INTR_ACK_ID)) ? i_out_port[3:0] : 4'h0;
        w_mask_next    = (i_io_strb && (i_port_id == INTR_MASK_ID)) ? i_out_port[3:0] : r_mask;
        w_pending_next = (r_pending & ~w_clear) | w_set;
    end

    // Pending events, mask, and the interrupt request (a registered copy of pending & mask)
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_pending <= 4'h0;
            r_mask    <= 4'h0;
            r_intr    <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
            r_mask    <= w_mask_next;
            r_intr    <= |(r_pending & r_mask);
        end
    end

    // IN read mux, purely combinational on PORT_ID
    always_comb begin
        case (i_port_id)
            SWITCHES_ID:  o_in_port = r_sw_s;
            BTN_LEVEL_ID: o_in_port = {4'h0, w_level};
            EVENT_ID:     o_in_port = {4'h0, r_pending};
            default:      o_in_port = 8'h00;
        endcase
    end

    assign o_intr = r_intr;

endmodule

// File: tb/tb_rat_input_port.sv
// Directed testbench for rat_input_port with DEBOUNCE_CYCLES=4.
// Inputs change and outputs are sampled just after the falling clock edge.
module tb_rat_input_port;

    logic       clk;
    logic       reset_n;
    logic [7:0] switches;
    logic [3:0] buttons;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       io_strb;
    logic [7:0] in_port;
    logic       intr;

    int total;
    int bad;

    rat_input_port #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .i_clk      (clk),
        .i_reset_n  (reset_n),
        .i_switches (switches),
        .i_buttons  (buttons),
        .i_port_id  (port_id),
        .i_out_port (out_port),
        .i_io_strb  (io_strb),
        .o_in_port  (in_port),
        .o_intr     (intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic rd(input string tag, input logic [7:0] id, input logic [7:0] exp);
        port_id = id;
        #1;
        chk(tag, in_port, exp);
    endtask

    // One OUT transaction: strobe is seen on the next rising edge
    task automatic wr(input logic [7:0] id, input logic [7:0] data);
        port_id  = id;
        out_port = data;
        io_strb  = 1'b1;
        @(negedge clk);
        io_strb  = 1'b0;
        out_port = 8'h00;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset_n  = 1'b0;
        switches = 8'h00;
        buttons  = 4'hF;
        port_id  = 8'h00;
        out_port = 8'h00;
        io_strb  = 1'b0;

        // Reset with all buttons held
        step(2);
        chk("rst_intr", {7'b0, intr}, 8'h00);
        rd("rst_event", 8'hFE, 8'h00);
        rd("rst_level", 8'hFD, 8'h00);
        reset_n = 1'b1;
        step(5);
        rd("rst_level_c5", 8'hFD, 8'h00);
        step(1);
        rd("rst_level_c6", 8'hFD, 8'h0F);
        rd("rst_event_c6", 8'hFE, 8'h0F);
        step(2);
        chk("rst_intr_unmasked", {7'b0, intr}, 8'h00);

        // Release all, then clear everything
        buttons = 4'h0;
        step(8);
        rd("release_level", 8'hFD, 8'h00);
        rd("release_no_event", 8'hFE, 8'h0F);
        wr(8'h82, 8'h0F);
        rd("ack_all", 8'hFE, 8'h00);

        // Press button 0 with mask bit 0 set
        wr(8'h83, 8'h01);
        buttons = 4'h1;
        step(5);
        rd("press_level_c5", 8'hFD, 8'h00);
        rd("press_event_c5", 8'hFE, 8'h00);
        step(1);
        rd("press_level_c6", 8'hFD, 8'h01);
        rd("press_event_c6", 8'hFE, 8'h01);
        chk("press_intr_c6", {7'b0, intr}, 8'h00);
        step(1);
        chk("press_intr_c7", {7'b0, intr}, 8'h01);

        // Glitch on button 1 shorter than the debounce window
        buttons = 4'h3;
        step(3);
        buttons = 4'h1;
        step(8);
        rd("glitch_level", 8'hFD, 8'h01);
        rd("glitch_event", 8'hFE, 8'h01);

        // Real press on button 1, then acknowledge bit 0
        buttons = 4'h3;
        step(6);
        rd("press1_event", 8'hFE, 8'h03);
        wr(8'h82, 8'h01);
        rd("ack0_event", 8'hFE, 8'h02);
        chk("ack0_intr_lag", {7'b0, intr}, 8'h01);
        step(1);
        chk("ack0_intr_fall", {7'b0, intr}, 8'h00);

        // Clear of bit 2 on the very edge that sets it
        wr(8'h83, 8'h04);
        buttons = 4'h7;
        step(5);
        port_id  = 8'h82;
        out_port = 8'h04;
        io_strb  = 1'b1;
        step(1);
        io_strb  = 1'b0;
        out_port = 8'h00;
        rd("collide_event", 8'hFE, 8'h06);
        rd("collide_level", 8'hFD, 8'h07);
        step(1);
        chk("collide_intr", {7'b0, intr}, 8'h01);
        step(2);
        chk("collide_intr_hold", {7'b0, intr}, 8'h01);
        wr(8'h82, 8'h04);
        rd("ack2_event", 8'hFE, 8'h02);
        step(1);
        chk("ack2_intr", {7'b0, intr}, 8'h00);

        // Reads and unrelated writes
        switches = 8'hA5;
        step(1);
        rd("sw_lag1", 8'hFF, 8'h00);
        step(1);
        rd("sw_lag2", 8'hFF, 8'hA5);
        rd("other_id", 8'h10, 8'h00);
        wr(8'h40, 8'hFF);
        rd("wr40_event", 8'hFE, 8'h02);
        step(1);
        chk("wr40_intr", {7'b0, intr}, 8'h00);
        wr(8'h83, 8'hF2);
        step(1);
        chk("mask2_intr", {7'b0, intr}, 8'h01);
        wr(8'h83, 8'hF0);
        step(1);
        chk("mask_hi_ignored", {7'b0, intr}, 8'h00);

        // Reset while buttons are held: one event after release
        reset_n = 1'b0;
        step(2);
        rd("rst2_event", 8'hFE, 8'h00);
        reset_n = 1'b1;
        step(5);
        rd("rst2_event_c5", 8'hFE, 8'h00);
        step(1);
        rd("rst2_event_c6", 8'hFE, 8'h07);
        rd("rst2_level_c6", 8'hFD, 8'h07);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
